// File: rtl/mac_out_serializer_if.sv
// Handshake bundle for mac_out_serializer: result-word input strobe and
// byte-stream output with ready/valid flow control.
interface mac_out_serializer_if;
   logic        in_valid;
   logic [40:0] in_data;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;

   modport slave  (input  in_valid, in_data, out_ready,
                   output out_valid, out_data, out_last);
   modport master (output in_valid, in_data, out_ready,
                   input  out_valid, out_data, out_last);
endinterface

// File: rtl/mac_out_serializer.sv
// Buffers 41-bit MAC results in a small FIFO and streams each one out LSB-byte first.
// Define MAC_SER_CHECKSUM_EN to append an XOR checksum byte to every word.
module mac_out_serializer #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   mac_out_serializer_if.slave  bus,
   output logic                 busy,
   output logic                 overflow
);

`ifdef MAC_SER_CHECKSUM_EN
   localparam int unsigned N = 7;
`else
   localparam int unsigned N = 6;
`endif
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [2:0]    LAST_IDX = 3'(N - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state, state_nxt;
   logic [40:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [2:0]    byte_idx, idx_nxt;
   logic [40:0]   head;
   logic          xfer, last_byte, pop, full, push, drop;
`ifdef MAC_SER_CHECKSUM_EN
   logic [7:0]    chk;
`endif

   always_comb begin
      head      = mem[rd_ptr];
      xfer      = ena && (state == SEND) && bus.out_ready;
      last_byte = (byte_idx == LAST_IDX);
      pop       = xfer && last_byte;
      full      = (count == FULL_CNT);
      // A full FIFO still accepts a word when the head pops on the same edge.
      push      = ena && bus.in_valid && (!full || pop);
      drop      = ena && bus.in_valid && full && !pop;

      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;

      idx_nxt = byte_idx;
      if (xfer)
         idx_nxt = last_byte ? '0 : byte_idx + 3'd1;

      state_nxt = state;
      case (state)
         IDLE: if (push) state_nxt = SEND;
         SEND: if (count_nxt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MAC_SER_CHECKSUM_EN
   always_comb begin
      chk = head[7:0] ^ head[15:8] ^ head[23:16] ^ head[31:24] ^ head[39:32]
          ^ {7'b0, head[40]};
   end
`endif

   always_comb begin
      bus.out_valid = (state == SEND);
      bus.out_last  = bus.out_valid && last_byte;
      busy          = (count != '0);
      bus.out_data  = '0;
      if (state == SEND) begin
         case (byte_idx)
            3'd0: bus.out_data = head[7:0];
            3'd1: bus.out_data = head[15:8];
            3'd2: bus.out_data = head[23:16];
            3'd3: bus.out_data = head[31:24];
            3'd4: bus.out_data = head[39:32];
            3'd5: bus.out_data = {7'b0, head[40]};
`ifdef MAC_SER_CHECKSUM_EN
            3'd6: bus.out_data = chk;
`endif
            default: bus.out_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         byte_idx <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         byte_idx <= idx_nxt;
         if (push)
            wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_out_serializer.sv
// Self-checking bench for mac_out_serializer: table-driven words plus hand-written
// sequences for overflow, full-FIFO push/pop, enable hold and mid-word reset.
module tb_mac_out_serializer;
`ifdef MAC_SER_CHECKSUM_EN
   localparam int unsigned N = 7;
`else
   localparam int unsigned N = 6;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic ena;
   logic busy;
   logic overflow;

   mac_out_serializer_if u_if();

   mac_out_serializer #(.FIFO_DEPTH(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .bus      (u_if),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_bytes  = 0;
   logic [8:0] exp_q [$];

   typedef struct {
      logic [40:0]     word;
      bit              stall;
      logic [6:0][7:0] bytes;
   } vec_t;
   vec_t tbl [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0][7:0] model_bytes(input logic [40:0] w);
      logic [6:0][7:0] b;
      logic [47:0]     x;
      x = {7'b0, w};
      for (int k = 0; k < 6; k++) b[k] = x[8*k +: 8];
      b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
      return b;
   endfunction

   task automatic push_exp(input logic [6:0][7:0] b);
      for (int k = 0; k < int'(N); k++) exp_q.push_back({1'(k == int'(N) - 1), b[k]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit stall, input string name);
      int c = 0;
      while (busy && c < 60) begin
         if (stall) u_if.out_ready = ~u_if.out_ready;
         else       u_if.out_ready = 1'b1;
         tick();
         c++;
      end
      check(name, busy, 0);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      ena            = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.in_data   = '0;
      u_if.out_ready = 1'b0;
      exp_q.delete();
      tick();
      tick();
      check("rst_out_valid", u_if.out_valid, 0);
      check("rst_out_data",  u_if.out_data,  0);
      check("rst_out_last",  u_if.out_last,  0);
      check("rst_busy",      busy,           0);
      check("rst_overflow",  overflow,       0);
      rst_n = 1'b1;
      tick();
   endtask

   // Byte monitor: transfers are predicted at the negedge before the edge that takes them.
   logic       hold_prev = 1'b0;
   logic [9:0] held;
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n) begin
         if (hold_prev)
            check("stall_hold", {u_if.out_valid, u_if.out_last, u_if.out_data}, held);
         if (ena && u_if.out_valid && u_if.out_ready) begin
            n_bytes++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h expected none", u_if.out_data);
            end else begin
               e = exp_q.pop_front();
               check("byte", {u_if.out_last, u_if.out_data}, e);
            end
         end
         hold_prev = u_if.out_valid && !(ena && u_if.out_ready);
         held      = {u_if.out_valid, u_if.out_last, u_if.out_data};
      end else begin
         hold_prev = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [40:0]     wa, wb, wc, wd;
      logic [6:0][7:0] mb;
      logic [7:0]      saved;
      int              c, n0;

      tbl[0] = '{41'h00123456789, 1'b0, {8'h89, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89}};
      tbl[1] = '{41'h1FFFFFFFFFF, 1'b1, {8'hFE, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
      tbl[2] = '{41'h00000000000, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[3] = '{41'h10000000001, 1'b0, {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}};
      tbl[4] = '{41'h0AA55AA55AA, 1'b1, {8'hAA, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA}};

      do_reset();

      for (int i = 0; i < 5; i++) begin
         u_if.out_ready = !tbl[i].stall;
         u_if.in_valid  = 1'b1;
         u_if.in_data   = tbl[i].word;
         push_exp(tbl[i].bytes);
         check("pre_valid", u_if.out_valid, 0);
         tick();
         u_if.in_valid = 1'b0;
         check("valid_latency", u_if.out_valid, 1);
         check("busy_high", busy, 1);
         drain(tbl[i].stall, "table_drain");
         check("table_q_empty", exp_q.size(), 0);
      end

      // Three strobes into a 2-deep FIFO with no draining: third word dropped
      wa = 41'h0DEADBEEF01; wb = 41'h1CAFEF00D02; wc = 41'h0123ABCDE03;
      u_if.out_ready = 1'b0;
      u_if.in_valid  = 1'b1;
      u_if.in_data   = wa; push_exp(model_bytes(wa)); tick();
      u_if.in_data   = wb; push_exp(model_bytes(wb)); tick();
      check("ovf_before_drop", overflow, 0);
      u_if.in_data   = wc; tick();
      u_if.in_valid  = 1'b0;
      check("ovf_set", overflow, 1);
      check("ovf_busy", busy, 1);
      n0 = n_bytes;
      drain(1'b0, "ovf_drain");
      check("ovf_byte_count", n_bytes - n0, 2 * N);
      check("ovf_sticky", overflow, 1);

      do_reset();

      // Full FIFO, push coincident with the head word's last-byte transfer
      wd = 41'h0F0E0D0C0B0;
      u_if.out_ready = 1'b0;
      u_if.in_valid  = 1'b1;
      u_if.in_data   = wa; push_exp(model_bytes(wa)); tick();
      u_if.in_data   = wb; push_exp(model_bytes(wb)); tick();
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      c = 0;
      while (!(u_if.out_valid && u_if.out_last) && c < 20) begin
         tick();
         c++;
      end
      check("full_last_seen", u_if.out_last, 1);
      u_if.in_valid = 1'b1;
      u_if.in_data  = wd;
      push_exp(model_bytes(wd));
      tick();
      u_if.in_valid = 1'b0;
      mb = model_bytes(wb);
      check("full_push_ovf", overflow, 0);
      check("full_next_valid", u_if.out_valid, 1);
      check("full_next_byte0", u_if.out_data, mb[0]);
      drain(1'b0, "full_drain");
      check("full_ovf_after", overflow, 0);

      // ena=0 holds all state and ignores in_valid/out_ready
      u_if.out_ready = 1'b1;
      u_if.in_valid  = 1'b1;
      u_if.in_data   = wc;
      push_exp(model_bytes(wc));
      tick();
      u_if.in_valid = 1'b0;
      tick();
      tick();
      saved         = u_if.out_data;
      ena           = 1'b0;
      u_if.in_valid = 1'b1;
      u_if.in_data  = wd;
      repeat (3) tick();
      check("ena_hold_data", u_if.out_data, saved);
      check("ena_hold_valid", u_if.out_valid, 1);
      check("ena_hold_ovf", overflow, 0);
      ena           = 1'b1;
      u_if.in_valid = 1'b0;
      drain(1'b0, "ena_drain");
      check("ena_q_empty", exp_q.size(), 0);

      // Reset asserted right after byte 2 of a word
      u_if.out_ready = 1'b1;
      u_if.in_valid  = 1'b1;
      u_if.in_data   = wb;
      push_exp(model_bytes(wb));
      n0 = n_bytes;
      tick();
      u_if.in_valid = 1'b0;
      c = 0;
      while (n_bytes < n0 + 3 && c < 20) begin
         tick();
         c++;
      end
      check("midrst_bytes_sent", n_bytes - n0, 3);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", u_if.out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", u_if.out_data, 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("midrst_quiet", u_if.out_valid, 0);

      check("final_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_out_serializer.md
MAC_OUT_SERIALIZER -- requirements
Module: mac_out_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of 41-bit result words buffered; legal values 2 and 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  active-high enable; when low, the block SHALL hold all state.
REQ-005 in_valid  input  1  one-cycle strobe: in_data carries a completed MAC result.
REQ-006 in_data  input  41  unsigned MAC result word.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_data  output  8  current result byte.
REQ-010 out_last  output  1  high with the final byte of a word.
REQ-011 busy  output  1  high while the FIFO holds at least one word.
REQ-012 overflow  output  1  sticky flag: a result word was dropped.

Function
REQ-013 The block SHALL capture in_data into the FIFO tail on any clock edge where ena=1 and in_valid=1, provided a slot is free or is freed that same edge.
REQ-014 Byte transfer SHALL occur only on edges where ena=1, out_valid=1 and out_ready=1.
REQ-015 Word bytes SHALL be sent LSB first: byte k = in_data[8k+7:8k] for k=0..4; byte 5 = {7'b0, in_data[40]}.
REQ-016 FSM states SHALL be IDLE (FIFO empty, out_valid=0) and SEND (out_valid=1, byte index 0..N-1).
REQ-017 IDLE->SEND on the edge after a capture into an empty FIFO; out_valid SHALL be high exactly one cycle after the in_valid cycle.
REQ-018 On a transfer with byte index < N-1, the index SHALL increment; with index = N-1, the word SHALL pop, the index SHALL reset to 0, and the FSM SHALL stay in SEND if another word remains, else go to IDLE.
REQ-019 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Push and pop on the same edge with FIFO full SHALL both succeed; the occupancy count SHALL be unchanged.
REQ-021 in_valid with FIFO full and no pop on that edge SHALL drop the word, leave the FIFO unchanged and set overflow, which SHALL stay high until reset.
REQ-022 With ena=0, in_valid SHALL be ignored (no capture, no overflow) and out_ready SHALL be ignored; outputs hold.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 busy SHALL equal (occupancy != 0).
REQ-025 out_last SHALL equal out_valid AND (byte index = N-1).

Reset
REQ-026 On rst_n low, the block SHALL asynchronously clear the FIFO pointers and count, the byte index, the checksum and overflow, and enter IDLE.
REQ-027 Reset values: out_valid=0, out_data=8'h00, out_last=0, busy=0, overflow=0.
REQ-028 Reset mid-word SHALL discard all buffered and partially sent words; no byte SHALL be emitted after reset release until a new capture.

Configuration
REQ-029 Macro MAC_SER_CHECKSUM_EN defined: N=7; byte 6 SHALL be the XOR of bytes 0..5 of the same word, and out_last SHALL mark byte 6.
REQ-030 Macro MAC_SER_CHECKSUM_EN undefined: N=6; no checksum logic SHALL be present, and out_last SHALL mark byte 5.

Verification
REQ-031 Reset then in_valid with in_data=41'h00123456789, out_ready=1 -> out_valid starting the next cycle; bytes 89,67,45,23,01,00; out_last on 00; busy falls after the last byte.
REQ-032 Same word with MAC_SER_CHECKSUM_EN defined -> bytes 89,67,45,23,01,00,89 with out_last on the 7th byte.
REQ-033 in_data=41'h1FFFFFFFFFF, out_ready toggled 0/1 every cycle -> bytes FF x5 then 01, each held stable while stalled.
REQ-034 FIFO_DEPTH=2, out_ready=0, three in_valid strobes -> first two words kept, third dropped, overflow=1; then out_ready=1 -> exactly 12 bytes emitted, overflow stays 1.
REQ-035 FIFO full, in_valid coincident with the last-byte transfer -> new word accepted, overflow stays 0, its byte 0 appears the next cycle.
REQ-036 rst_n pulsed low after byte 2 of a word -> out_valid=0 immediately, busy=0, no further bytes emitted until a new in_valid.
